// File: rtl/mt_thread_sched.sv
// Round-robin fetch thread scheduler with stall / rewind / resume handling.
// Optional macro STALL_TIMEOUT_EN: force release of WAIT after STALL_TIMEOUT cycles.
module mt_thread_sched #(
  parameter int NUM_THREADS      = 4,
  parameter int NUM_THREAD_GRPS  = 2,
  parameter int BITS_THREADS     = $clog2(NUM_THREADS),
  parameter int BITS_THREAD_GRPS = $clog2(NUM_THREAD_GRPS),
  parameter int STALL_TIMEOUT    = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_THREADS*NUM_THREAD_GRPS-1:0] thread_en,
  input  logic                                   stall_req,
  input  logic [BITS_THREAD_GRPS-1:0]            stall_tgrp_in,
  input  logic [BITS_THREADS-1:0]                stall_tid_in,
  input  logic                                   stall_release,
  output logic [BITS_THREAD_GRPS-1:0]            tgrp,
  output logic [BITS_THREADS-1:0]                tid,
  output logic                                   issue_valid,
  output logic                                   sub_pcs,
  output logic [BITS_THREAD_GRPS-1:0]            tgrp_stalled,
  output logic [BITS_THREADS-1:0]                tid_stalled
);

  localparam int TOT = NUM_THREADS * NUM_THREAD_GRPS;
  localparam int LW  = BITS_THREAD_GRPS + BITS_THREADS;

  typedef enum logic [1:0] {
    RUN,
    REWIND,
    WAIT
  } state_t;

  state_t          state;
  logic            restart;
  logic [LW-1:0]   base;
  logic [LW-1:0]   nxt;
  logic            tmo_hit;

  // After reset the search starts just below index 0 so index 0 is eligible
  assign base = restart ? LW'(TOT - 1) : {tgrp, tid};

  // Next enabled linear index above base, wrapping around
  always_comb begin
    logic          found;
    logic [LW-1:0] j;
    nxt   = base;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= TOT; k++) begin
      j = LW'((int'(base) + k) % TOT);
      if (!found && thread_en[j]) begin
        nxt   = j;
        found = 1'b1;
      end
    end
  end

`ifdef STALL_TIMEOUT_EN
  logic [31:0] cnt;

  assign tmo_hit = (cnt == 32'(STALL_TIMEOUT - 1));

  // Counts WAIT cycles from WAIT entry
  always_ff @(posedge clk) begin
    if (rst || state != WAIT)
      cnt <= '0;
    else
      cnt <= cnt + 32'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Scheduler FSM with registered fetch selection and stall bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      restart      <= 1'b1;
      tgrp         <= '0;
      tid          <= '0;
      issue_valid  <= 1'b0;
      sub_pcs      <= 1'b0;
      tgrp_stalled <= '0;
      tid_stalled  <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (stall_req) begin
            state        <= REWIND;
            tgrp_stalled <= stall_tgrp_in;
            tid_stalled  <= stall_tid_in;
            tgrp         <= stall_tgrp_in;
            tid          <= stall_tid_in;
            sub_pcs      <= 1'b1;
            issue_valid  <= 1'b0;
          end else if (|thread_en) begin
            {tgrp, tid}  <= nxt;
            issue_valid  <= 1'b1;
            restart      <= 1'b0;
          end else begin
            issue_valid  <= 1'b0;
          end
        end
        REWIND: begin
          state   <= WAIT;
          sub_pcs <= 1'b0;
        end
        WAIT: begin
          if (stall_release || tmo_hit) begin
            state       <= RUN;
            restart     <= 1'b0;
            tgrp        <= tgrp_stalled;
            tid         <= tid_stalled;
            issue_valid <= 1'b1;
          end
        end
        default: begin
          state       <= RUN;
          issue_valid <= 1'b0;
          sub_pcs     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mt_thread_sched.sv
// Directed vector bench for mt_thread_sched (default 4x2 configuration).
// Vectors carry inputs plus the hand-computed registered outputs after the edge.
module tb_mt_thread_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] thread_en;
  logic       stall_req;
  logic [0:0] stall_tgrp_in;
  logic [1:0] stall_tid_in;
  logic       stall_release;
  logic [0:0] tgrp;
  logic [1:0] tid;
  logic       issue_valid;
  logic       sub_pcs;
  logic [0:0] tgrp_stalled;
  logic [1:0] tid_stalled;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mt_thread_sched dut (
    .clk          (clk),
    .rst          (rst),
    .thread_en    (thread_en),
    .stall_req    (stall_req),
    .stall_tgrp_in(stall_tgrp_in),
    .stall_tid_in (stall_tid_in),
    .stall_release(stall_release),
    .tgrp         (tgrp),
    .tid          (tid),
    .issue_valid  (issue_valid),
    .sub_pcs      (sub_pcs),
    .tgrp_stalled (tgrp_stalled),
    .tid_stalled  (tid_stalled)
  );

  typedef struct {
    logic [7:0] en;
    logic       sreq;
    logic [2:0] sidx;
    logic       srel;
    logic [7:0] exp;
  } vec_t;

  vec_t vq[$];

  // {idx, issue_valid, sub_pcs, stalled idx}
  function automatic logic [7:0] e(int idx, bit v, bit s, int sidx);
    logic [2:0] a;
    logic [2:0] b;
    a = idx[2:0];
    b = sidx[2:0];
    return {a, v, s, b};
  endfunction

  task automatic add(logic [7:0] en, logic sreq, int sidx,
                     logic srel, logic [7:0] exp);
    vec_t v;
    v.en   = en;
    v.sreq = sreq;
    v.sidx = sidx[2:0];
    v.srel = srel;
    v.exp  = exp;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [7:0] exp);
    logic [7:0] act;
    act = {tgrp, tid, issue_valid, sub_pcs, tgrp_stalled, tid_stalled};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got idx=%0d v=%0b sub=%0b sidx=%0d want idx=%0d v=%0b sub=%0b sidx=%0d",
               name, act[7:5], act[4], act[3], act[2:0],
               exp[7:5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic drive(logic [7:0] en, logic sreq, int sidx, logic srel);
    logic [2:0] s;
    s = sidx[2:0];
    thread_en     = en;
    stall_req     = sreq;
    stall_tgrp_in = s[2];
    stall_tid_in  = s[1:0];
    stall_release = srel;
  endtask

  initial begin
    rst = 1'b1;
    drive(8'h00, 1'b0, 0, 1'b0);

    for (int i = 0; i < 8; i++) add(8'hFF, 0, 0, 0, e(i, 1, 0, 0));
    add(8'hFF, 0, 0, 0, e(0, 1, 0, 0));
    add(8'h85, 0, 0, 0, e(2, 1, 0, 0));
    add(8'h85, 0, 0, 0, e(7, 1, 0, 0));
    add(8'h85, 0, 0, 0, e(0, 1, 0, 0));
    add(8'h85, 0, 0, 0, e(2, 1, 0, 0));
    add(8'h85, 1, 6, 1, e(6, 0, 1, 6));
    add(8'h85, 1, 0, 0, e(6, 0, 0, 6));
    add(8'h85, 1, 0, 0, e(6, 0, 0, 6));
    add(8'h85, 1, 0, 0, e(6, 0, 0, 6));
    add(8'h85, 0, 0, 1, e(6, 1, 0, 6));
    add(8'h85, 0, 0, 0, e(7, 1, 0, 6));
    add(8'h85, 0, 0, 0, e(0, 1, 0, 6));
    add(8'h85, 0, 0, 0, e(2, 1, 0, 6));
    add(8'h85, 0, 0, 1, e(7, 1, 0, 6));
    add(8'h85, 1, 5, 0, e(5, 0, 1, 5));
    add(8'h85, 0, 0, 1, e(5, 0, 0, 5));
    add(8'h85, 0, 0, 1, e(5, 1, 0, 5));
    add(8'h85, 0, 0, 0, e(7, 1, 0, 5));
    add(8'h85, 0, 0, 0, e(0, 1, 0, 5));
    add(8'h00, 0, 0, 0, e(0, 0, 0, 5));
    add(8'h10, 0, 0, 0, e(4, 1, 0, 5));

    step();
    step();
    chk("reset", e(0, 0, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].en, vq[i].sreq, int'(vq[i].sidx), vq[i].srel);
      step();
      chk($sformatf("vec%0d", i), vq[i].exp);
    end

    drive(8'h85, 1'b1, 3, 1'b0);
    step();
    chk("rw_stall", e(3, 0, 1, 3));
    drive(8'h85, 1'b0, 0, 1'b0);
    step();
    chk("rw_wait", e(3, 0, 0, 3));
    rst = 1'b1;
    step();
    chk("rst_in_wait", e(0, 0, 0, 0));
    rst = 1'b0;
    drive(8'h0C, 1'b0, 0, 1'b0);
    step();
    chk("first_after_rst", e(2, 1, 0, 0));

    drive(8'h0C, 1'b1, 4, 1'b0);
    step();
    chk("rr_stall", e(4, 0, 1, 4));
    drive(8'h0C, 1'b0, 0, 1'b0);
    rst = 1'b1;
    step();
    chk("rst_in_rewind", e(0, 0, 0, 0));
    rst = 1'b0;
    drive(8'hFF, 1'b0, 0, 1'b0);
    step();
    chk("after_rst_rewind", e(0, 1, 0, 0));

    drive(8'hFF, 1'b1, 1, 1'b0);
    step();
    chk("to_stall", e(1, 0, 1, 1));
    drive(8'hFF, 1'b0, 0, 1'b0);
    step();
    chk("to_wait1", e(1, 0, 0, 1));
    for (int i = 2; i <= 8; i++) begin
      step();
      chk($sformatf("to_wait%0d", i), e(1, 0, 0, 1));
    end
`ifdef STALL_TIMEOUT_EN
    step();
    chk("to_resume", e(1, 1, 0, 1));
    step();
    chk("to_rr", e(2, 1, 0, 1));
`else
    for (int i = 9; i <= 13; i++) begin
      step();
      chk($sformatf("to_wait%0d", i), e(1, 0, 0, 1));
    end
    stall_release = 1'b1;
    step();
    chk("rel_resume", e(1, 1, 0, 1));
    stall_release = 1'b0;
    step();
    chk("rel_rr", e(2, 1, 0, 1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
